mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter_pkg.sv | 24 ++
 rtl/mem_port_arbiter_rr_arb2.sv | 39 +++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester byte-RAM port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

    localparam int AW_DEF = 10;
    localparam int DW_DEF = 8;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef enum logic {
        RD = 1'b0,
        WR = 1'b1
    } req_type_e;

    // Tag carried alongside an access through the issue and return stages.
    typedef struct packed {
        logic vld;   // an access occupies this stage
        logic port;  // PORT0 / PORT1
        logic rd;    // access is a read and will return data
    } tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// 2-way round-robin grant generator; holds the priority pointer.
// Latency: grant is combinational from req; pointer moves at the next edge.
// Backpressure: none; a granted requester is assumed to take its grant.
//
// Ports: clk, reset (sync, active-high), req[1:0], advance (commit pointer
// move on a grant this cycle), gnt[1:0] (one-hot or zero).
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    // Port favoured when both request; reset favours port 0.
    logic ptr;

    always_comb begin
        gnt = 2'b00;
        if (req == 2'b11) begin
            gnt = (ptr == PORT1) ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    // After any grant the pointer moves to the port that did not win, so a
    // lone winner also loses priority for the next contended cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= PORT0;
        end else if (advance && (gnt != 2'b00)) begin
            ptr <= gnt[0] ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port byte RAM between two requesters, round-robin.
// Latency: ack in cycle N, RAM pins driven in N+1, read data/rvalid in N+2.
// Backpressure: req held until ack; losing requester waits at most one cycle.
//
// Ports: clk, reset (sync, active-high);
//   per requester X in {0,1}: reqX, weX, addrX, wdataX in; ackX, rvalidX,
//   rdataX out;
//   RAM side: mem_we, mem_addr, mem_di out; mem_do in (registered RAM output).
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,

    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,

    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_di,
    input  logic [DW-1:0] mem_do
);

    logic [1:0]    req_v;
    logic [1:0]    gnt;
    logic          any_gnt;
    logic          win_port;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    tag_t          iss_tag;
    tag_t          ret_tag;

    // Requests are masked during reset so no ack can leak out.
    assign req_v = {req1, req0} & {2{~reset}};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .req     (req_v),
        .advance (~reset),
        .gnt     (gnt)
    );

    assign ack0    = gnt[0];
    assign ack1    = gnt[1];
    assign any_gnt = |gnt;

    assign win_port  = gnt[1] ? PORT1 : PORT0;
    assign win_we    = gnt[1] ? we1    : we0;
    assign win_addr  = gnt[1] ? addr1  : addr0;
    assign win_wdata = gnt[1] ? wdata1 : wdata0;

    // Issue stage drives the RAM pins; return stage lines up with mem_do.
    // Address/data hold on idle cycles so the RAM pins stay quiet.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_di   <= '0;
            iss_tag  <= '0;
            ret_tag  <= '0;
        end else begin
            mem_we  <= any_gnt && (win_we == WR);
            if (any_gnt) begin
                mem_addr <= win_addr;
                mem_di   <= win_wdata;
            end
            iss_tag.vld  <= any_gnt;
            iss_tag.port <= win_port;
            iss_tag.rd   <= (win_we == RD);
            ret_tag      <= iss_tag;
        end
    end

    assign rvalid0 = ret_tag.vld && ret_tag.rd && (ret_tag.port == PORT0);
    assign rvalid1 = ret_tag.vld && ret_tag.rd && (ret_tag.port == PORT1);

    // Data is only meaningful alongside rvalid; both ports see the RAM output.
    assign rdata0 = mem_do;
    assign rdata1 = mem_do;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int NC = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [9:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       ack0, ack1, rvalid0, rvalid1;
    logic [7:0] rdata0, rdata1;
    logic       mem_we;
    logic [9:0] mem_addr;
    logic [7:0] mem_di;
    logic [7:0] mem_do;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(10), .DW(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
    );

    // Behavioural byte RAM: write-first, one-cycle registered read.
    logic [7:0] ram [1024];
    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_di;
        mem_do <= mem_we ? mem_di : ram[mem_addr];
    end

    // Reference model: memory contents in grant order, plus per-cycle
    // expected events (issue at grant+1, return at grant+2).
    logic [7:0] ref_mem [1024];
    int         ptr_m = 0;
    int         cyc = 0;
    bit         is_vld [NC];
    bit         is_we  [NC];
    bit         clr    [NC];
    bit         rv0    [NC];
    bit         rv1    [NC];
    logic [9:0] is_addr [NC];
    logic [7:0] is_di   [NC];
    logic [7:0] rdx     [NC];
    logic [9:0] last_addr = '0;
    logic [7:0] last_di = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic do_cycle(input bit rst,
                            input bit r0, input bit w0, input logic [9:0] a0, input logic [7:0] d0,
                            input bit r1, input bit w1, input logic [9:0] a1, input logic [7:0] d1,
                            output int g);
        bit ewe;
        @(posedge clk);
        #1;
        reset = rst;
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        #4;
        if (rst)           g = -1;
        else if (r0 && r1) g = ptr_m;
        else if (r0)       g = 0;
        else if (r1)       g = 1;
        else               g = -1;
        chk("ack0", 32'(ack0), 32'(g == 0));
        chk("ack1", 32'(ack1), 32'(g == 1));

        if (is_vld[cyc]) begin
            ewe = is_we[cyc];
            last_addr = is_addr[cyc];
            last_di = is_di[cyc];
        end else begin
            ewe = 1'b0;
            if (clr[cyc]) begin
                last_addr = '0;
                last_di = '0;
            end
        end
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", 32'(mem_addr), 32'(last_addr));
        chk("mem_di", 32'(mem_di), 32'(last_di));
        chk("rvalid0", 32'(rvalid0), 32'(rv0[cyc]));
        chk("rvalid1", 32'(rvalid1), 32'(rv1[cyc]));
        if (rv0[cyc]) chk("rdata0", 32'(rdata0), 32'(rdx[cyc]));
        if (rv1[cyc]) chk("rdata1", 32'(rdata1), 32'(rdx[cyc]));

        if (rst) begin
            ptr_m = 0;
            clr[cyc+1] = 1'b1;
            rv0[cyc+1] = 1'b0;
            rv1[cyc+1] = 1'b0;
        end else if (g >= 0) begin
            ptr_m = 1 - g;
            is_vld[cyc+1] = 1'b1;
            is_we[cyc+1] = (g == 0) ? w0 : w1;
            is_addr[cyc+1] = (g == 0) ? a0 : a1;
            is_di[cyc+1] = (g == 0) ? d0 : d1;
            if (is_we[cyc+1]) begin
                ref_mem[is_addr[cyc+1]] = is_di[cyc+1];
            end else begin
                if (g == 0) rv0[cyc+2] = 1'b1;
                else        rv1[cyc+2] = 1'b1;
                rdx[cyc+2] = ref_mem[is_addr[cyc+1]];
            end
        end
        cyc++;
    endtask

    function automatic logic [9:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 10'h3FF;
        return 10'($urandom_range(0, 15));
    endfunction

    typedef struct {
        bit rst;
        bit r0; bit w0; logic [9:0] a0; logic [7:0] d0;
        bit r1; bit w1; logic [9:0] a1; logic [7:0] d1;
        bit ea0; bit ea1; bit ewe; logic [9:0] eaddr; logic [7:0] edi;
        bit erv0; bit erv1; logic [7:0] erd;
    } vec_t;

    vec_t tbl [$];

    int         g;
    int         gap0, gap1;
    bit         rs;
    bit         p0 = 1'b0, p1 = 1'b0, pw0, pw1;
    logic [9:0] pa0, pa1;
    logic [7:0] pd0, pd1;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            ram[i] = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < NC; i++) begin
            is_vld[i] = 1'b0; is_we[i] = 1'b0; clr[i] = 1'b0;
            rv0[i] = 1'b0; rv1[i] = 1'b0;
            is_addr[i] = '0; is_di[i] = '0; rdx[i] = '0;
        end
        clr[0] = 1'b1;

        // rst | r0 w0 a0 d0 | r1 w1 a1 d1 || ack0 ack1 we addr di rv0 rv1 rdata
        // reset held with both requesting
        for (int i = 0; i < 3; i++)
            tbl.push_back('{1'b1, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b0,1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,8'h00});
        // contention: 0,1,0,1,0,1
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b1,1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b0,1'b1,1'b0,10'h010,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b1,1'b0,1'b0,10'h020,8'h00, 1'b1,1'b0,8'h4A});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b0,1'b1,1'b0,10'h010,8'h00, 1'b0,1'b1,8'h7A});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b1,1'b0,1'b0,10'h020,8'h00, 1'b1,1'b0,8'h4A});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b0,1'b1,1'b0,10'h010,8'h00, 1'b0,1'b1,8'h7A});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h020,8'h00, 1'b1,1'b0,8'h4A});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h020,8'h00, 1'b0,1'b1,8'h7A});
        // port 0 write 0x005=0x3C, then read it back
        tbl.push_back('{1'b0, 1'b1,1'b1,10'h005,8'h3C, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,1'b0,10'h020,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h005,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,1'b1,10'h005,8'h3C, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h005,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h005,8'h00, 1'b1,1'b0,8'h3C});
        // write 0x3FF=0xA5 on port 0, port 1 reads it the next cycle
        tbl.push_back('{1'b0, 1'b1,1'b1,10'h3FF,8'hA5, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,1'b0,10'h005,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,10'h3FF,8'h00, 1'b0,1'b1,1'b1,10'h3FF,8'hA5, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h3FF,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h3FF,8'h00, 1'b0,1'b1,8'hA5});
        // port 1 read of 0x001 acked, reset the next cycle kills its return
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,10'h001,8'h00, 1'b0,1'b1,1'b0,10'h3FF,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b1, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h001,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b1,1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b0,1'b1,1'b0,10'h010,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h020,8'h00, 1'b1,1'b0,8'h4A});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h020,8'h00, 1'b0,1'b1,8'h7A});
        // pointer hold: port 1 alone, three idle cycles, then both -> port 0
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b0,1'b1,1'b0,10'h020,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h020,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h020,8'h00, 1'b0,1'b1,8'h7A});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h020,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b1,1'b0,10'h010,8'h00, 1'b1,1'b0,10'h020,8'h00, 1'b1,1'b0,1'b0,10'h020,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h010,8'h00, 1'b0,1'b0,8'h00});
        tbl.push_back('{1'b0, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,10'h000,8'h00, 1'b0,1'b0,1'b0,10'h010,8'h00, 1'b1,1'b0,8'h4A});

        foreach (tbl[i]) begin
            do_cycle(tbl[i].rst, tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
                     tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, g);
            chk($sformatf("tbl%0d_ack0", i), 32'(ack0), 32'(tbl[i].ea0));
            chk($sformatf("tbl%0d_ack1", i), 32'(ack1), 32'(tbl[i].ea1));
            chk($sformatf("tbl%0d_mem_we", i), 32'(mem_we), 32'(tbl[i].ewe));
            chk($sformatf("tbl%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].eaddr));
            chk($sformatf("tbl%0d_mem_di", i), 32'(mem_di), 32'(tbl[i].edi));
            chk($sformatf("tbl%0d_rvalid0", i), 32'(rvalid0), 32'(tbl[i].erv0));
            chk($sformatf("tbl%0d_rvalid1", i), 32'(rvalid1), 32'(tbl[i].erv1));
            if (tbl[i].erv0) chk($sformatf("tbl%0d_rdata0", i), 32'(rdata0), 32'(tbl[i].erd));
            if (tbl[i].erv1) chk($sformatf("tbl%0d_rdata1", i), 32'(rdata1), 32'(tbl[i].erd));
        end

        // Both held continuously: neither may go more than one cycle unserved.
        gap0 = 0;
        gap1 = 0;
        for (int i = 0; i < 10; i++) begin
            do_cycle(1'b0, 1'b1, 1'b0, 10'h00A, 8'h00, 1'b1, 1'b0, 10'h00B, 8'h00, g);
            gap0 = ack0 ? 0 : gap0 + 1;
            gap1 = ack1 ? 0 : gap1 + 1;
            chk("hold_gap0", 32'(gap0 <= 1), 32'd1);
            chk("hold_gap1", 32'(gap1 <= 1), 32'd1);
        end

        // Randomised traffic; requesters hold until granted, occasional reset.
        for (int n = 0; n < 1500; n++) begin
            rs = ($urandom_range(0, 63) == 0);
            if (!p0 && $urandom_range(0, 1) == 1) begin
                p0 = 1'b1; pw0 = 1'($urandom_range(0, 1)); pa0 = rand_addr(); pd0 = 8'($urandom);
            end
            if (!p1 && $urandom_range(0, 1) == 1) begin
                p1 = 1'b1; pw1 = 1'($urandom_range(0, 1)); pa1 = rand_addr(); pd1 = 8'($urandom);
            end
            do_cycle(rs, p0, pw0, pa0, pd0, p1, pw1, pa1, pd1, g);
            if (g == 0) p0 = 1'b0;
            if (g == 1) p1 = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
